// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and sizing constants for the radix-2 divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = $clog2(DEF_WIDTH + 1);
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step on an already-shifted partial remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   pr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] nr,
  output logic             qb
);
  logic [WIDTH:0] diff;
  assign diff = pr - {1'b0, d};
  assign qb   = pr >= {1'b0, d};
  assign nr   = qb ? diff[WIDTH-1:0] : pr[WIDTH-1:0];
endmodule

// File: rtl/div.sv
// div: multi-cycle restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour sgn (signed mode); otherwise every operation is unsigned.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             sgn,
  input  logic             start,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] rem
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p, q, d, nr, nq, a_mag, b_mag, rd_n, rem_n;
  logic             qb;
  div_step #(.WIDTH(WIDTH)) u_step (
    .pr({p, q[WIDTH-1]}),
    .d (d),
    .nr(nr),
    .qb(qb)
  );
  assign nq = {q[WIDTH-2:0], qb};
`ifdef DIV_SIGNED_EN
  logic an, bn, neg_q, neg_r, dz;
  assign an    = sgn & r1[WIDTH-1];
  assign bn    = sgn & r2[WIDTH-1];
  assign a_mag = an ? -r1 : r1;
  assign b_mag = bn ? -r2 : r2;
  // Zero divisor must give all ones regardless of the sign fix-up.
  assign rd_n  = dz ? '1 : neg_q ? -nq : nq;
  assign rem_n = neg_r ? -nr : nr;
  always_ff @(posedge CLK)
    if (state == IDLE) begin
      neg_q <= an ^ bn;
      neg_r <= an;
      dz    <= r2 == '0;
    end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_mag = r1;
  assign b_mag = r2;
  assign rd_n  = nq;
  assign rem_n = nr;
`endif
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      rd    <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            p     <= '0;
            q     <= a_mag;
            d     <= b_mag;
            cnt   <= '0;
            ready <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          p   <= nr;
          q   <= nq;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            rd    <= rd_n;
            rem   <= rem_n;
            valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
